onehot_strobe_dec: RTL and testbench
====================================

Name: onehot_strobe_dec

Overview:
- Sequential binary-to-one-hot decoder; the inverse of the team's 4-input priority encoder.
- Accepts an encoded index over a valid/ready handshake and drives exactly one output line high for HOLD clock cycles.
- Then returns to idle and pulses done.
- Used to drive select/strobe lines from encoded requests; gated by an enable in the same way as the encoder.

Parameters:
- W, 2, code width; output width is 2**W (default 4).
- HOLD, 3, strobe length in cycles; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- enable  input  1  block enable; low = abort/idle, no new accepts.
- in_valid  input  1  code presented.
- in_code  input  W  encoded index, bit W-1 = MSB.
- in_ready  output  1  block can accept a code.
- o  output  2**W  one-hot strobe; o[in_code] high while strobing.
- busy  output  1  high while strobing.
- done  output  1  one-cycle pulse when a strobe completes normally.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, o=0, done=0, busy=0, counter=0.
  - in_ready=0 while rst_n low.
- States: IDLE, STROBE.
- in_ready is combinational: rst_n & enable & (state==IDLE). busy = (state==STROBE).
- IDLE:
  - Accept occurs at an edge where in_valid & in_ready.
  - At that edge: o <= 1<<in_code, counter <= HOLD-1, state <= STROBE.
  - No accept: o stays 0.
- STROBE:
  - o is held constant.
  - Each edge with counter!=0: counter decrements.
  - At the edge with counter==0: o <= 0, done <= 1, state <= IDLE.
- Timing: accept at edge k gives o high for exactly HOLD cycles (edges k..k+HOLD). At edge k+HOLD, done=1 for one cycle and o=0.
- done is registered; it deasserts at the next edge.
- in_ready is high during the done cycle, so the earliest back-to-back accept is at edge k+HOLD+1. This guarantees at least one cycle of o=0 between strobes.
- in_valid during STROBE is ignored; nothing is queued. The producer holds in_valid until in_ready.
- All in_code values 0..2**W-1 are legal. One-hotness of o is guaranteed by construction.
- Counter width is clog2(HOLD+1). HOLD=1 gives a single-cycle strobe, with the counter loaded as 0.
- enable low:
  - In IDLE: no accept.
  - In STROBE: at the next edge o <= 0, state <= IDLE, counter <= 0, no done pulse (abort).
  - enable low has priority over counter expiry in the same cycle: no done pulse.
- Async reset mid-strobe: o drops immediately, no done pulse.
- in_code is sampled only at the accept edge; later changes do not affect o.

Optional Feature:
- Macro: ONEHOT_STROBE_DEC_COUNT_EN.
- Defined:
  - Adds output port strobe_cnt [15:0], reset 0.
  - Increments in the same edge that sets done.
  - Saturates at 16'hFFFF; aborted strobes are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package dec_pkg:
  - State typedef (IDLE=0, STROBE=1).
  - Localparam DEC_DEFAULT_W=2.
  - Localparam DEC_CNT_W=16 for the optional counter.
- One sub-module, strobe_timer:
  - Loadable down-counter with load, clear and expired outputs.
  - Parameterised on HOLD.
  - Instantiated once.
- The decode and state machine stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then rst_n=1, enable=1, in_valid=0 -> o=4'b0000, done=0, busy=0, in_ready=1.
- Single decode, HOLD=3, W=2, in_code=2'b10 accepted -> o=4'b0100 for exactly 3 cycles, then o=0 with done=1 for 1 cycle, in_ready=0 during the strobe.
- Back-to-back sweep: in_valid held high with codes 0,1,2,3 -> o steps 0001,0010,0100,1000. Each lasts 3 cycles with one o=0/done cycle between strobes; 4 done pulses total.
- Abort: enable dropped in the 2nd strobe cycle of code 3 -> o=0 next cycle, no done pulse, in_ready=0 until enable=1, then the next code is accepted normally.
- Async reset mid-strobe: rst_n=0 between edges while o=4'b0010 -> o=0 immediately, busy=0, no done pulse after release.
- ONEHOT_STROBE_DEC_COUNT_EN defined, HOLD=1: 5 completed strobes plus 1 abort -> strobe_cnt=5. Force the counter to 16'hFFFE, then complete 3 strobes -> strobe_cnt=16'hFFFF.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and constants for the one-hot strobe decoder.
package dec_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STROBE = 1'b1
  } state_t;

  localparam int DEC_DEFAULT_W = 2;
  localparam int DEC_CNT_W     = 16;

  function automatic logic [DEC_CNT_W-1:0] sat_inc(input logic [DEC_CNT_W-1:0] v);
    return (v == '1) ? v : v + DEC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/onehot_strobe_dec_strobe_timer.sv
// Loadable down-counter timing the strobe length; expired when it reaches zero.
module strobe_timer #(
  parameter int HOLD = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/onehot_strobe_dec.sv
// Binary-to-one-hot strobe decoder: holds o[code] high for HOLD cycles, then pulses done.
// Build option ONEHOT_STROBE_DEC_COUNT_EN adds a saturating completed-strobe counter.
module onehot_strobe_dec
  import dec_pkg::*;
#(
  parameter int W    = DEC_DEFAULT_W,
  parameter int HOLD = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            in_valid,
  input  logic [W-1:0]    in_code,
  output logic            in_ready,
  output logic [2**W-1:0] o,
  output logic            busy,
  output logic            done
`ifdef ONEHOT_STROBE_DEC_COUNT_EN
  ,
  output logic [DEC_CNT_W-1:0] strobe_cnt
`endif
);

  localparam int OW = 2**W;

  state_t state;
  logic   accept;
  logic   abort;
  logic   expired;
  logic   finish;

  assign in_ready = rst_n & enable & (state == IDLE);
  assign busy     = (state == STROBE);
  assign accept   = in_valid & in_ready;
  assign abort    = (state == STROBE) & ~enable;
  // Abort wins over expiry, so an expiring strobe with enable low gives no done.
  assign finish   = (state == STROBE) & enable & expired;

  strobe_timer #(
    .HOLD(HOLD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .clear  (abort),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            o     <= OW'(1) << in_code;
            state <= STROBE;
          end
        end
        STROBE: begin
          if (abort) begin
            o     <= '0;
            state <= IDLE;
          end else if (finish) begin
            o     <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          o     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ONEHOT_STROBE_DEC_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_cnt <= '0;
    end else if (finish) begin
      strobe_cnt <= sat_inc(strobe_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_onehot_strobe_dec.sv
// Randomised bench for onehot_strobe_dec against a cycles-remaining reference model.
module tb_onehot_strobe_dec;

  localparam int W    = 2;
  localparam int HOLD = 3;
  localparam int OW   = 2**W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_code = '0;
  logic          in_ready;
  logic [OW-1:0] o;
  logic          busy;
  logic          done;
`ifdef ONEHOT_STROBE_DEC_COUNT_EN
  logic [15:0]   strobe_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles of strobe left, active code, done flag, completed count.
  int m_left = 0;
  int m_code = 0;
  bit m_done = 1'b0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  onehot_strobe_dec #(
    .W   (W),
    .HOLD(HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .in_valid(in_valid),
    .in_code (in_code),
    .in_ready(in_ready),
    .o       (o),
    .busy    (busy),
    .done    (done)
`ifdef ONEHOT_STROBE_DEC_COUNT_EN
    ,
    .strobe_cnt(strobe_cnt)
`endif
  );

  function automatic logic [OW+2:0] expv();
    logic [OW-1:0] oe;
    oe = (m_left > 0) ? (OW'(1) << m_code) : '0;
    return {oe, (m_left > 0), m_done, (rst_n && enable && m_left == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    if (!rst_n) begin
      m_left = 0;
      m_cnt  = 0;
    end else if (m_left > 0) begin
      if (!enable) m_left = 0;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1'b1;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
      end
    end else if (enable && in_valid) begin
      m_left = HOLD;
      m_code = int'(in_code);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0;
    tick(); tick();
    n_tests++;
    if ({o, busy, done, in_ready} !== {{OW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_hold: got o=%b busy=%b done=%b rdy=%b, want all 0", o, busy, done, in_ready);
    end
    rst_n = 1'b1; enable = 1'b1;
    tick();
    n_tests++;
    if ({o, busy, done, in_ready} !== expv()) begin
      n_fail++;
      $display("FAIL reset_idle: got %b want %b", {o, busy, done, in_ready}, expv());
    end
  endtask

  task automatic test_single();
    int high_cycles = 0;
    in_code = 2'b10; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < HOLD + 2; i++) begin
      if (o == 4'b0100) high_cycles++;
      n_tests++;
      if ({o, busy, done, in_ready} !== expv()) begin
        n_fail++;
        $display("FAIL single[%0d]: got %b want %b", i, {o, busy, done, in_ready}, expv());
      end
      tick();
    end
    n_tests++;
    if (high_cycles != HOLD) begin
      n_fail++;
      $display("FAIL single_len: got %0d cycles want %0d", high_cycles, HOLD);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int dones = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 4 * (HOLD + 1) + 4; i++) begin
      in_code = W'(idx);
      tick();
      if (m_left == HOLD && idx < 4) idx++;
      if (idx == 4) in_valid = 1'b0;
      if (done) dones++;
      n_tests++;
      if ({o, busy, done, in_ready} !== expv()) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %b want %b", i, {o, busy, done, in_ready}, expv());
      end
    end
    n_tests++;
    if (dones != 4) begin
      n_fail++;
      $display("FAIL b2b_dones: got %0d want 4", dones);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    in_code = 2'b11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
      n_tests++;
      if ({o, busy, done, in_ready} !== expv()) begin
        n_fail++;
        $display("FAIL abort[%0d]: got %b want %b", i, {o, busy, done, in_ready}, expv());
      end
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d pulses want 0", dones);
    end
    enable = 1'b1; in_code = 2'b01; in_valid = 1'b1;
    for (int i = 0; i < HOLD + 3; i++) begin
      tick();
      in_valid = 1'b0;
      n_tests++;
      if ({o, busy, done, in_ready} !== expv()) begin
        n_fail++;
        $display("FAIL abort_resume[%0d]: got %b want %b", i, {o, busy, done, in_ready}, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    int dones = 0;
    in_code = 2'b01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    m_left = 0; m_done = 1'b0; m_cnt = 0;
    #1;
    n_tests++;
    if ({o, busy, done, in_ready} !== {{OW{1'b0}}, 3'b000}) begin
      n_fail++;
      $display("FAIL async_rst: got o=%b busy=%b done=%b rdy=%b, want all 0", o, busy, done, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < HOLD + 2; i++) begin
      tick();
      if (done) dones++;
      n_tests++;
      if ({o, busy, done, in_ready} !== expv()) begin
        n_fail++;
        $display("FAIL async_after[%0d]: got %b want %b", i, {o, busy, done, in_ready}, expv());
      end
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL async_done: got %0d pulses want 0", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      in_valid = $urandom_range(0, 1);
      in_code  = W'($urandom);
      tick();
      n_tests++;
      if ({o, busy, done, in_ready} !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b", i, {o, busy, done, in_ready}, expv());
      end
    end
    enable = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < HOLD + 2; i++) tick();
  endtask

`ifdef ONEHOT_STROBE_DEC_COUNT_EN
  task automatic test_count();
    n_tests++;
    if (int'(strobe_cnt) != m_cnt) begin
      n_fail++;
      $display("FAIL count_track: got %0d want %0d", strobe_cnt, m_cnt);
    end
    @(negedge clk);
    force dut.strobe_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.strobe_cnt;
    m_cnt = 16'hFFFE;
    for (int s = 0; s < 3; s++) begin
      in_code = W'(s); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < HOLD + 1; i++) tick();
    end
    n_tests++;
    if (strobe_cnt !== 16'hFFFF || m_cnt != 65535) begin
      n_fail++;
      $display("FAIL count_sat: got %h want ffff", strobe_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
`ifdef ONEHOT_STROBE_DEC_COUNT_EN
    test_count();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
